dec_seq_nto2n: RTL and testbench
================================

// Module: dec_seq_nto2n
// PURPOSE
//  Registered N-to-2^N decoder with enable, valid/ready select input and three output modes:
//  one-hot, thermometer and self-timed scan (walking one-hot).
//  Next-generation replacement for the fixed 2-to-4 combinational decoders.
//  Drives chip-select, row-select and LED/scan lines in larger designs.
// PARAMETERS
//  N          2  select width; output width is 2**N (localparam W). Legal range 1..6.
//  DWELL      4  scan mode: cycles each output stays active (>=1).
//  ACTIVE_LOW 0  1 = outputs active-low; inactive level is then all-ones.
// PORTS
//  clk        in   1    clock, rising edge
//  rst_n      in   1    async reset, active low
//  en         in   1    enable; low forces outputs inactive
//  mode       in   2    00 one-hot, 01 thermometer, 10 scan, 11 reserved
//  in_valid   in   1    sel valid
//  in_ready   out  1    block accepts sel this cycle
//  sel        in   N    select index (MSB = sel[N-1])
//  dec_out    out  W    decoded outputs; bit k corresponds to index k
//  out_valid  out  1    1-cycle pulse: dec_out updated from an accepted sel
//  scan_wrap  out  1    1-cycle pulse: scan index wrapped W-1 -> 0
//  busy       out  1    high while in SCAN
// BEHAVIOUR
//  Reset (async): dec_out = inactive (0s; 1s if ACTIVE_LOW), out_valid = 0, scan_wrap = 0,
//  busy = 0, state = IDLE, scan index = 0, dwell counter = 0. All outputs are registered.
//  Polarity: every value below is active-high; ACTIVE_LOW inverts dec_out only.
//  FSM states: IDLE, HOLD, SCAN.
//  - en = 0 (any state): next edge -> IDLE, dec_out inactive, pulses 0. Priority over all else.
//  - mode 11 with en = 1: behaves as en = 0.
//  - mode 00/01, IDLE or HOLD: in_ready = 1.
//    On in_valid & in_ready, the next edge sets dec_out and pulses out_valid; state -> HOLD.
//    Latency is 1 cycle.
//      one-hot:     dec_out = 1 << sel.
//      thermometer: dec_out[k] = (k <= sel), e.g. N=2, sel=2 -> 0111.
//  - HOLD: dec_out holds its last value until a new accept, en low, or a mode change.
//  - Changing between 00 and 01 in HOLD re-encodes the held sel at the next edge.
//    out_valid does not pulse on a re-encode.
//  - mode 10, en = 1, from IDLE/HOLD: next edge -> SCAN, index = 0, dec_out = one-hot(0),
//    dwell = 0, busy = 1.
//  - SCAN:
//    - in_ready = 0; in_valid is ignored and sel is not captured.
//    - dwell increments each cycle. When dwell = DWELL-1: dwell = 0 and index advances.
//    - Wrap: if index = W-1, it goes to 0 and scan_wrap pulses with the index-0 output.
//    - Each output stays active exactly DWELL cycles; the full period is W*DWELL cycles.
//  - Leaving SCAN (mode != 10, en high): next edge -> IDLE, dec_out inactive, busy = 0.
//    The scan index is not retained; re-entry starts at 0.
//  - in_ready is combinational from state, mode and en.
//  - in_valid in the same cycle as en = 0 or a mode change into 10 is not accepted (in_ready = 0).
//  - Reset mid-scan or mid-hold: immediate return to reset values; no pulse emitted.
//  - sel is unsigned, and all values 0..W-1 are legal (no out-of-range case).
// TESTING
//  1) Reset: rst_n = 0 mid-scan -> dec_out = 0000, busy = 0, in_ready = 0 until en = 1.
//  2) One-hot, N=2: en = 1, mode = 00, sel = 2'b10 accepted -> next cycle dec_out = 0100,
//     out_valid = 1 for 1 cycle; dec_out holds 0100 afterwards.
//  3) Thermometer, N=3: sel = 5 -> dec_out = 8'b0011_1111.
//     Then switch to mode 00 with no new sel -> 8'b0010_0000, out_valid stays 0.
//  4) Scan, N=2, DWELL=3: mode = 10 -> 0001 x3, 0010 x3, 0100 x3, 1000 x3, then 0001.
//     scan_wrap pulses on the first 0001 of the repeat; in_ready = 0 throughout.
//  5) en dropped for 1 cycle during HOLD -> dec_out goes to 0000 on the next edge.
//     Re-enable -> outputs stay 0000 until the next accepted sel.
//  6) ACTIVE_LOW=1, N=2, sel = 1 -> dec_out = 1101; mode 11 -> 1111.

Source files
------------

// File: rtl/dec_seq_nto2n.sv
// Registered N-to-2^N decoder: one-hot, thermometer and walking-one scan modes.
// Latency: 1 cycle from accepted sel (or mode/en change) to dec_out.
// Backpressure: in_ready low in SCAN, with en low, or for mode 10/11; sel is only captured when in_valid & in_ready.
module dec_seq_nto2n #(
    parameter int N          = 2,
    parameter int DWELL      = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N-1:0]      sel,
    output logic [2**N-1:0]   dec_out,
    output logic              out_valid,
    output logic              scan_wrap,
    output logic              busy
);

    localparam int W  = 2**N;
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_ONEHOT = 2'b00,
        MODE_THERM  = 2'b01,
        MODE_SCAN   = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_t;

    state_t          state_q, state_d;
    logic [W-1:0]    dec_q, dec_d;       // active-high image of dec_out
    logic [N-1:0]    sel_q, sel_d;       // last accepted select, kept for re-encode in HOLD
    logic [N-1:0]    idx_q, idx_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic            ov_q, ov_d;
    logic            wrap_q, wrap_d;
    logic            busy_q, busy_d;
    logic            mode_dec;           // mode is one of the two decode modes
    logic            accept;

    // One-hot (therm=0) or thermometer (therm=1) encoding of an index.
    function automatic logic [W-1:0] encode(input logic [N-1:0] s, input logic therm);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < W; k++) begin
            if (therm ? (k <= int'(s)) : (k == int'(s))) begin
                r[k] = 1'b1;
            end
        end
        return r;
    endfunction

    assign mode_dec = (mode == MODE_ONEHOT) || (mode == MODE_THERM);
    assign in_ready = en && mode_dec && (state_q != ST_SCAN);
    assign accept   = in_valid && in_ready;

    // Next-state and next-output logic; en low / reserved mode overrides everything.
    always_comb begin
        state_d = state_q;
        dec_d   = dec_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        ov_d    = 1'b0;
        wrap_d  = 1'b0;
        if (!en || (mode == MODE_RSVD)) begin
            state_d = ST_IDLE;
            dec_d   = '0;
            idx_d   = '0;
            dwell_d = '0;
        end else if (mode == MODE_SCAN) begin
            if (state_q != ST_SCAN) begin
                state_d = ST_SCAN;
                idx_d   = '0;
                dwell_d = '0;
                dec_d   = encode('0, 1'b0);
            end else if (dwell_q == DW'(DWELL - 1)) begin
                dwell_d = '0;
                if (idx_q == N'(W - 1)) begin
                    idx_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
                dec_d = encode(idx_d, 1'b0);
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
        end else begin
            if (state_q == ST_SCAN) begin
                // Scan position is dropped on exit so the next scan starts at index 0.
                state_d = ST_IDLE;
                dec_d   = '0;
                idx_d   = '0;
                dwell_d = '0;
            end else if (accept) begin
                state_d = ST_HOLD;
                sel_d   = sel;
                dec_d   = encode(sel, mode == MODE_THERM);
                ov_d    = 1'b1;
            end else if (state_q == ST_HOLD) begin
                // Re-encoding every cycle keeps the value stable and follows 00<->01 switches.
                dec_d = encode(sel_q, mode == MODE_THERM);
            end else begin
                dec_d = '0;
            end
        end
        busy_d = (state_d == ST_SCAN);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dec_q   <= '0;
            sel_q   <= '0;
            idx_q   <= '0;
            dwell_q <= '0;
            ov_q    <= 1'b0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dec_q   <= dec_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            ov_q    <= ov_d;
            wrap_q  <= wrap_d;
            busy_q  <= busy_d;
        end
    end

    assign dec_out   = dec_q ^ {W{ACTIVE_LOW}};
    assign out_valid = ov_q;
    assign scan_wrap = wrap_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dec_seq_nto2n.sv
// Directed bench for dec_seq_nto2n: three instances (N=2/DWELL=3, N=3/DWELL=4, N=2/DWELL=1 active-low).
// Latency: outputs sampled 1 time unit after each rising edge; in_ready sampled before the edge.
// Backpressure: in_ready checked against hand-computed values in every table vector.
module tb_dec_seq_nto2n;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic       in_valid;
    logic [1:0] sel_a, sel_c;
    logic [2:0] sel_b;

    logic       rdy_a, ov_a, wrap_a, busy_a;
    logic [3:0] dec_a;
    logic       rdy_b, ov_b, wrap_b, busy_b;
    logic [7:0] dec_b;
    logic       rdy_c, ov_c, wrap_c, busy_c;
    logic [3:0] dec_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dec_seq_nto2n #(.N(2), .DWELL(3), .ACTIVE_LOW(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(rdy_a), .sel(sel_a), .dec_out(dec_a), .out_valid(ov_a),
        .scan_wrap(wrap_a), .busy(busy_a));

    dec_seq_nto2n #(.N(3), .DWELL(4), .ACTIVE_LOW(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(rdy_b), .sel(sel_b), .dec_out(dec_b), .out_valid(ov_b),
        .scan_wrap(wrap_b), .busy(busy_b));

    dec_seq_nto2n #(.N(2), .DWELL(1), .ACTIVE_LOW(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(rdy_c), .sel(sel_c), .dec_out(dec_c), .out_valid(ov_c),
        .scan_wrap(wrap_c), .busy(busy_c));

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic       vld;
        logic [1:0] sel;
        logic       rdy;
        logic [3:0] dec;
        logic       ov;
        logic       wrap;
        logic       busy;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic addv(input logic e, input logic [1:0] m, input logic v, input logic [1:0] s,
                        input logic r, input logic [3:0] d, input logic o, input logic w,
                        input logic b);
        vec_t x;
        x.en = e; x.mode = m; x.vld = v; x.sel = s;
        x.rdy = r; x.dec = d; x.ov = o; x.wrap = w; x.busy = b;
        vt.push_back(x);
    endtask

    task automatic drive(input logic e, input logic [1:0] m, input logic v, input logic [2:0] s);
        en       = e;
        mode     = m;
        in_valid = v;
        sel_a    = s[1:0];
        sel_b    = s;
        sel_c    = s[1:0];
    endtask

    // Drive, let one rising edge pass, return 1 unit after it.
    task automatic step(input logic e, input logic [1:0] m, input logic v, input logic [2:0] s);
        drive(e, m, v, s);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Vector table for u_a (N=2, DWELL=3): en mode vld sel | rdy dec ov wrap busy
        addv(0, 2'b00, 0, 2'd0, 0, 4'b0000, 0, 0, 0);
        addv(1, 2'b00, 1, 2'd2, 1, 4'b0100, 1, 0, 0);   // one-hot accept
        addv(1, 2'b00, 0, 2'd0, 1, 4'b0100, 0, 0, 0);   // hold
        addv(1, 2'b00, 0, 2'd3, 1, 4'b0100, 0, 0, 0);   // sel without valid ignored
        addv(1, 2'b01, 0, 2'd0, 1, 4'b0111, 0, 0, 0);   // re-encode held 2 as thermometer
        addv(1, 2'b01, 1, 2'd1, 1, 4'b0011, 1, 0, 0);
        addv(1, 2'b00, 1, 2'd3, 1, 4'b1000, 1, 0, 0);
        addv(0, 2'b00, 1, 2'd0, 0, 4'b0000, 0, 0, 0);   // en low beats valid
        addv(1, 2'b00, 0, 2'd0, 1, 4'b0000, 0, 0, 0);   // stays inactive after re-enable
        addv(1, 2'b00, 0, 2'd0, 1, 4'b0000, 0, 0, 0);
        addv(1, 2'b10, 1, 2'd1, 0, 4'b0001, 0, 0, 1);   // enter scan, valid not accepted
        addv(1, 2'b10, 1, 2'd2, 0, 4'b0001, 0, 0, 1);
        addv(1, 2'b10, 0, 2'd0, 0, 4'b0001, 0, 0, 1);
        for (int k = 1; k < 4; k++) begin
            for (int j = 0; j < 3; j++) begin
                logic [3:0] oh;
                oh = 4'b0001 << k;
                addv(1, 2'b10, 0, 2'd0, 0, oh, 0, 0, 1);
            end
        end
        addv(1, 2'b10, 0, 2'd0, 0, 4'b0001, 0, 1, 1);   // wrap pulse with index 0
        addv(1, 2'b10, 0, 2'd0, 0, 4'b0001, 0, 0, 1);
        addv(1, 2'b00, 1, 2'd2, 0, 4'b0000, 0, 0, 0);   // leave scan, no accept
        addv(1, 2'b00, 0, 2'd0, 1, 4'b0000, 0, 0, 0);
        addv(1, 2'b10, 0, 2'd0, 0, 4'b0001, 0, 0, 1);   // re-entry starts at 0
        addv(1, 2'b10, 0, 2'd0, 0, 4'b0001, 0, 0, 1);
        addv(1, 2'b11, 1, 2'd1, 0, 4'b0000, 0, 0, 0);   // reserved mode = disabled
        addv(1, 2'b00, 1, 2'd1, 1, 4'b0010, 1, 0, 0);
        addv(1, 2'b11, 0, 2'd0, 0, 4'b0000, 0, 0, 0);
        addv(1, 2'b00, 0, 2'd0, 1, 4'b0000, 0, 0, 0);

        // Reset state
        rst_n = 1'b0;
        drive(0, 2'b00, 0, 3'd0);
        #12;
        chk("rst.dec_a", 64'(dec_a), 64'h0);
        chk("rst.dec_b", 64'(dec_b), 64'h0);
        chk("rst.dec_c", 64'(dec_c), 64'hF);
        chk("rst.ov_a", 64'(ov_a), 64'h0);
        chk("rst.busy_a", 64'(busy_a), 64'h0);
        chk("rst.rdy_a", 64'(rdy_a), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table-driven section on u_a
        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].en, vt[i].mode, vt[i].vld, {1'b0, vt[i].sel});
            #1;
            chk($sformatf("v%0d.rdy", i), 64'(rdy_a), 64'(vt[i].rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.dec", i), 64'(dec_a), 64'(vt[i].dec));
            chk($sformatf("v%0d.ov", i), 64'(ov_a), 64'(vt[i].ov));
            chk($sformatf("v%0d.wrap", i), 64'(wrap_a), 64'(vt[i].wrap));
            chk($sformatf("v%0d.busy", i), 64'(busy_a), 64'(vt[i].busy));
        end

        // Asynchronous reset in the middle of a scan
        for (int i = 0; i < 5; i++) step(1, 2'b10, 0, 3'd0);
        chk("midscan.pre_dec", 64'(dec_a), 64'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midscan.dec", 64'(dec_a), 64'h0);
        chk("midscan.busy", 64'(busy_a), 64'h0);
        chk("midscan.wrap", 64'(wrap_a), 64'h0);
        chk("midscan.ov", 64'(ov_a), 64'h0);
        drive(0, 2'b10, 0, 3'd0);
        #1;
        chk("midscan.rdy_en0", 64'(rdy_a), 64'h0);
        @(posedge clk);
        #1;
        chk("midscan.dec_held", 64'(dec_a), 64'h0);
        rst_n = 1'b1;
        drive(1, 2'b00, 0, 3'd0);
        #1;
        chk("midscan.rdy_en1", 64'(rdy_a), 64'h1);

        // u_b: N=3 thermometer / one-hot and DWELL=4 scan step
        step(0, 2'b00, 0, 3'd0);
        step(1, 2'b01, 1, 3'd5);
        chk("b.therm5", 64'(dec_b), 64'h3F);
        chk("b.therm5.ov", 64'(ov_b), 64'h1);
        step(1, 2'b00, 0, 3'd0);
        chk("b.reenc_oh5", 64'(dec_b), 64'h20);
        chk("b.reenc.ov", 64'(ov_b), 64'h0);
        step(1, 2'b00, 1, 3'd7);
        chk("b.oh7", 64'(dec_b), 64'h80);
        step(1, 2'b01, 1, 3'd0);
        chk("b.therm0", 64'(dec_b), 64'h01);
        step(1, 2'b01, 1, 3'd7);
        chk("b.therm7", 64'(dec_b), 64'hFF);
        step(1, 2'b10, 0, 3'd0);
        chk("b.scan0", 64'(dec_b), 64'h01);
        chk("b.scan.busy", 64'(busy_b), 64'h1);
        for (int i = 0; i < 3; i++) step(1, 2'b10, 0, 3'd0);
        chk("b.scan_dwell_end", 64'(dec_b), 64'h01);
        step(1, 2'b10, 0, 3'd0);
        chk("b.scan1", 64'(dec_b), 64'h02);

        // u_c: active-low outputs, DWELL=1 scan
        step(0, 2'b00, 0, 3'd0);
        chk("c.idle", 64'(dec_c), 64'hF);
        step(1, 2'b00, 1, 3'd1);
        chk("c.oh1", 64'(dec_c), 64'hD);
        chk("c.oh1.ov", 64'(ov_c), 64'h1);
        step(1, 2'b11, 1, 3'd2);
        chk("c.rsvd", 64'(dec_c), 64'hF);
        step(1, 2'b10, 0, 3'd0);
        chk("c.scan0", 64'(dec_c), 64'hE);
        step(1, 2'b10, 0, 3'd0);
        chk("c.scan1", 64'(dec_c), 64'hD);
        step(1, 2'b10, 0, 3'd0);
        chk("c.scan2", 64'(dec_c), 64'hB);
        step(1, 2'b10, 0, 3'd0);
        chk("c.scan3", 64'(dec_c), 64'h7);
        chk("c.scan3.wrap", 64'(wrap_c), 64'h0);
        step(1, 2'b10, 0, 3'd0);
        chk("c.wrap.dec", 64'(dec_c), 64'hE);
        chk("c.wrap", 64'(wrap_c), 64'h1);
        step(1, 2'b10, 0, 3'd0);
        chk("c.after_wrap", 64'(wrap_c), 64'h0);
        step(1, 2'b00, 0, 3'd0);
        chk("c.exit.dec", 64'(dec_c), 64'hF);
        chk("c.exit.busy", 64'(busy_c), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
